duck_motion: RTL

Per-frame position and heading generator for one duck sprite. Advances the duck once per video frame through fly, hit, fall and escape phases. Emits a packed 20-bit position and a 2-bit heading with a one-cycle load strobe. It sits directly upstream of the sprite position/heading holding registers, which capture `pos_out` and `dir_out` when `load` is high.

---
 rtl/duck_motion.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/duck_motion.sv
// Per-frame position/heading generator for one duck sprite (fly, hit, fall, escape).
// Optional DUCK_RANDOM_BOUNCE_EN: LFSR-driven vertical heading on horizontal bounces.
module duck_motion #(
  parameter int unsigned X_MIN         = 0,
  parameter int unsigned X_MAX         = 607,
  parameter int unsigned Y_MIN         = 0,
  parameter int unsigned Y_MAX         = 399,
  parameter int unsigned X_START       = 320,
  parameter int unsigned STEP          = 4,
  parameter int unsigned FALL_STEP     = 6,
  parameter int unsigned HIT_FRAMES    = 30,
  parameter int unsigned ESCAPE_FRAMES = 600
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_tick,
  input  logic        launch,
  input  logic        shot_hit,
  output logic [19:0] pos_out,
  output logic [1:0]  dir_out,
  output logic        load,
  output logic        busy,
  output logic        done,
  output logic        escaped
);

  typedef enum logic [2:0] {
    S_IDLE, S_FLY, S_HIT, S_FALL, S_ESCAPE, S_DONE
  } state_t;

  localparam logic [10:0] LP_STEP   = 11'(STEP);
  localparam logic [10:0] LP_FSTEP  = 11'(FALL_STEP);
  localparam logic [10:0] LP_X_LO   = 11'(X_MIN + STEP);
  localparam logic [10:0] LP_Y_LO   = 11'(Y_MIN + STEP);
  localparam logic [10:0] LP_X_MAX  = 11'(X_MAX);
  localparam logic [10:0] LP_Y_MAX  = 11'(Y_MAX);
  localparam logic [9:0]  LP_ESC_N  = 10'(ESCAPE_FRAMES);
  localparam logic [7:0]  LP_HIT_N  = 8'(HIT_FRAMES);

  state_t      r_state;
  logic [9:0]  r_x, r_y;
  logic [1:0]  r_dir;
  logic        r_load, r_busy, r_done, r_escaped;
  logic [9:0]  r_frame_cnt;
  logic [7:0]  r_hit_cnt;

  logic [10:0] w_x11, w_y11, w_x_add, w_y_add, w_y_fall_sum;
  logic [9:0]  w_x_fly, w_y_fly, w_y_esc, w_y_fall;
  logic        w_x_bounce, w_y_bounce, w_dir1_hb, w_dir1_next;
  logic [9:0]  w_frame_inc;
  logic [7:0]  w_hit_inc;

  assign w_x11        = {1'b0, r_x};
  assign w_y11        = {1'b0, r_y};
  assign w_x_add      = w_x11 + LP_STEP;
  assign w_y_add      = w_y11 + LP_STEP;
  assign w_y_fall_sum = w_y11 + LP_FSTEP;
  assign w_frame_inc  = r_frame_cnt + 10'd1;
  assign w_hit_inc    = r_hit_cnt + 8'd1;

  // Underflow is detected before subtracting so the 11-bit result never wraps.
  always_comb begin
    w_x_fly    = r_x;
    w_x_bounce = 1'b0;
    if (r_dir[0]) begin
      if (w_x11 < LP_X_LO) begin
        w_x_fly    = 10'(X_MIN);
        w_x_bounce = 1'b1;
      end else begin
        w_x_fly    = r_x - 10'(STEP);
      end
    end else begin
      if (w_x_add > LP_X_MAX) begin
        w_x_fly    = 10'(X_MAX);
        w_x_bounce = 1'b1;
      end else begin
        w_x_fly    = w_x_add[9:0];
      end
    end
  end

  always_comb begin
    w_y_fly    = r_y;
    w_y_bounce = 1'b0;
    if (r_dir[1]) begin
      if (w_y11 < LP_Y_LO) begin
        w_y_fly    = 10'(Y_MIN);
        w_y_bounce = 1'b1;
      end else begin
        w_y_fly    = r_y - 10'(STEP);
      end
    end else begin
      if (w_y_add > LP_Y_MAX) begin
        w_y_fly    = 10'(Y_MAX);
        w_y_bounce = 1'b1;
      end else begin
        w_y_fly    = w_y_add[9:0];
      end
    end
  end

  assign w_y_esc  = (w_y11 < LP_Y_LO) ? 10'(Y_MIN) : (r_y - 10'(STEP));
  assign w_y_fall = (w_y_fall_sum > LP_Y_MAX) ? 10'(Y_MAX) : w_y_fall_sum[9:0];

`ifdef DUCK_RANDOM_BOUNCE_EN
  logic [7:0] r_lfsr;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_lfsr <= 8'hA5;
    end else if (frame_tick) begin
      r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    end
  end

  assign w_dir1_hb = w_x_bounce ? r_lfsr[0] : r_dir[1];
`else
  assign w_dir1_hb = r_dir[1];
`endif

  // Vertical toggle applies after any random reassignment from a horizontal bounce.
  assign w_dir1_next = w_dir1_hb ^ w_y_bounce;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state     <= S_IDLE;
      r_x         <= 10'(X_START);
      r_y         <= 10'(Y_MAX);
      r_dir       <= 2'b10;
      r_load      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_escaped   <= 1'b0;
      r_frame_cnt <= '0;
      r_hit_cnt   <= '0;
    end else begin
      r_load <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (launch) begin
            r_state     <= S_FLY;
            r_x         <= 10'(X_START);
            r_y         <= 10'(Y_MAX);
            r_dir       <= 2'b10;
            r_frame_cnt <= '0;
            r_escaped   <= 1'b0;
            r_load      <= 1'b1;
            r_busy      <= 1'b1;
          end
        end
        S_FLY: begin
          if (shot_hit) begin
            r_state   <= S_HIT;
            r_hit_cnt <= '0;
            r_dir     <= 2'b00;
            r_load    <= 1'b1;
          end else if (frame_tick) begin
            r_x         <= w_x_fly;
            r_y         <= w_y_fly;
            r_dir       <= {w_dir1_next, r_dir[0] ^ w_x_bounce};
            r_frame_cnt <= w_frame_inc;
            r_load      <= 1'b1;
            if (w_frame_inc == LP_ESC_N) r_state <= S_ESCAPE;
          end
        end
        S_ESCAPE: begin
          if (frame_tick) begin
            r_y    <= w_y_esc;
            r_dir  <= 2'b10;
            r_load <= 1'b1;
            if (w_y_esc == 10'(Y_MIN)) begin
              r_state   <= S_DONE;
              r_done    <= 1'b1;
              r_escaped <= 1'b1;
            end
          end
        end
        S_HIT: begin
          if (frame_tick) begin
            r_hit_cnt <= w_hit_inc;
            r_load    <= 1'b1;
            if (w_hit_inc == LP_HIT_N) r_state <= S_FALL;
          end
        end
        S_FALL: begin
          if (frame_tick) begin
            r_y    <= w_y_fall;
            r_dir  <= 2'b00;
            r_load <= 1'b1;
            if (w_y_fall == 10'(Y_MAX)) begin
              r_state   <= S_DONE;
              r_done    <= 1'b1;
              r_escaped <= 1'b0;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign pos_out = {r_x, r_y};
  assign dir_out = r_dir;
  assign load    = r_load;
  assign busy    = r_busy;
  assign done    = r_done;
  assign escaped = r_escaped;

endmodule
